// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: bundle geometry, fetch-state encoding and the
// slot-index helper used by fetch, loader and decode.
package vliw_pkg;

  localparam int SLOTS    = 8;
  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int BUNDLE_W = SLOTS * WORD_W;
  localparam int CNT_W    = $clog2(SLOTS);

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_e;

  // Word k of a bundle lives at [slot_lsb(k) +: WORD_W]; word 0 is the MSB slot.
  function automatic int slot_lsb(input int k);
    return WORD_W * (SLOTS - 1 - k);
  endfunction

endpackage

// File: rtl/vliw_bundle_fetch_if.sv
// Instruction-memory read port and fetch-to-decode bundle handshake.
interface vliw_bundle_fetch_if;
  import vliw_pkg::*;

  logic                imem_rd_en;
  logic [ADDR_W-1:0]   imem_addr;
  logic [WORD_W-1:0]   imem_rdata;
  logic                bundle_valid;
  logic                bundle_ready;
  logic [BUNDLE_W-1:0] bundle_data;
  logic [ADDR_W-1:0]   bundle_pc;
  logic [SLOTS-1:0]    slot_mask;

  modport master (
    output imem_rd_en, imem_addr, bundle_valid, bundle_data, bundle_pc, slot_mask,
    input  imem_rdata, bundle_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, bundle_valid, bundle_data, bundle_pc, slot_mask,
    output imem_rdata, bundle_ready
  );

endinterface

// File: rtl/vliw_bundle_assembler.sv
// Collects returning memory words into the bundle slot register and derives
// the NOP mask and the end-of-program (all-zero) flag.
module vliw_bundle_assembler
  import vliw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                rd_issue,
  input  logic [WORD_W-1:0]   rdata,
  output logic                last_cap,
  output logic                all_zero,
  output logic [BUNDLE_W-1:0] bundle,
  output logic [SLOTS-1:0]    mask
);

  logic                cap_vld;
  logic [CNT_W-1:0]    cap_cnt;
  logic [BUNDLE_W-1:0] slot_q;
  logic [BUNDLE_W-1:0] slot_d;

  // Next slot-register contents; the zero test looks at this so that the word
  // arriving on the last capture is included.
  always_comb begin
    slot_d = slot_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (cap_vld && (cap_cnt == CNT_W'(k))) slot_d[slot_lsb(k) +: WORD_W] = rdata;
    end
  end

  // Per-slot nonzero mask from the assembled bundle.
  always_comb begin
    mask = '0;
    for (int k = 0; k < SLOTS; k++) mask[SLOTS-1-k] = |slot_q[slot_lsb(k) +: WORD_W];
  end

  assign last_cap = cap_vld && (cap_cnt == CNT_W'(SLOTS - 1));
  assign all_zero = (slot_d == '0);
  assign bundle   = slot_q;

  // Capture pipeline: data follows the strobe by one cycle; clr restarts the slot index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld <= 1'b0;
      cap_cnt <= '0;
      slot_q  <= '0;
    end else begin
      cap_vld <= rd_issue;
      slot_q  <= slot_d;
      if (clr)          cap_cnt <= '0;
      else if (cap_vld) cap_cnt <= cap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vliw_bundle_fetch.sv
// VLIW fetch front end: owns the bundle PC, issues SLOTS word reads per
// bundle, presents the assembled bundle to decode and stops on an all-zero bundle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FS_IDLE  | waiting for start (or a redirect) to load pc
// FS_FETCH | issuing reads at pc..pc+SLOTS-1 and capturing the replies
// FS_HOLD  | bundle_valid high, waiting for decode to accept
module vliw_bundle_fetch
  import vliw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                busy,
  output logic                done,
  vliw_bundle_fetch_if.master bus
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W:0]      issue_q, issue_d;
  logic                done_q, done_d;
  logic                fetch_init;
  logic                rd_en;
  logic                hold;
  logic                last_cap;
  logic                all_zero;
  logic [BUNDLE_W-1:0] asm_bundle;
  logic [SLOTS-1:0]    asm_mask;

  // issue_q counts reads still to be issued for the current bundle.
  assign rd_en = (state_q == FS_FETCH) && (issue_q != '0);
  assign hold  = (state_q == FS_HOLD);

  // Next-state logic; a redirect overrides everything, including a HOLD handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_d    = issue_q;
    done_d     = 1'b0;
    fetch_init = 1'b0;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      fetch_init = 1'b1;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            pc_d       = start_pc;
            fetch_init = 1'b1;
          end
        end
        FS_FETCH: begin
          if (rd_en) issue_d = issue_q - (CNT_W+1)'(1);
          if (last_cap) begin
            if (all_zero) begin
              state_d = FS_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (bus.bundle_ready) begin
            pc_d       = pc_q + ADDR_W'(SLOTS);
            fetch_init = 1'b1;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
    if (fetch_init) begin
      state_d = FS_FETCH;
      issue_d = (CNT_W+1)'(SLOTS);
    end
  end

  // State, pc, issue counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      issue_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      issue_q <= issue_d;
      done_q  <= done_d;
    end
  end

  // A read issued in a redirect cycle belongs to the abandoned fetch, so it is
  // never marked for capture.
  vliw_bundle_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fetch_init),
    .rd_issue (rd_en & ~redirect_valid),
    .rdata    (bus.imem_rdata),
    .last_cap (last_cap),
    .all_zero (all_zero),
    .bundle   (asm_bundle),
    .mask     (asm_mask)
  );

  assign bus.imem_rd_en   = rd_en;
  assign bus.imem_addr    = rd_en ? (pc_q + ADDR_W'(SLOTS) - ADDR_W'(issue_q)) : '0;
  assign bus.bundle_valid = hold;
  assign bus.bundle_data  = hold ? asm_bundle : '0;
  assign bus.bundle_pc    = hold ? pc_q : '0;
  assign bus.slot_mask    = hold ? asm_mask : '0;
  assign busy             = (state_q != FS_IDLE);
  assign done             = done_q;

endmodule

// File: doc/vliw_bundle_fetch.md
# vliw_bundle_fetch

Instruction-fetch front end of the VLIW processor: reads the word-addressed instruction memory that the loader fills, assembles eight consecutive 32-bit words into one 256-bit bundle, and hands it to decode over a valid/ready handshake. It owns the bundle PC, follows branch redirects, and stops at an all-zero bundle, which marks end of program.

## Interface
- SLOTS, 8, instruction slots per bundle; also the PC stride in words
- WORD_W, 32, width of one slot and one memory word
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse in IDLE; begins fetching at start_pc
- start_pc  in  ADDR_W  first bundle word address
- redirect_valid  in  1  branch or jump taken; overrides everything
- redirect_pc  in  ADDR_W  new bundle word address
- imem_rd_en  out  1  memory read strobe
- imem_addr  out  ADDR_W  memory word address
- imem_rdata  in  WORD_W  read data, valid exactly 1 cycle after the strobe
- bundle_valid  out  1  bundle_data, bundle_pc and slot_mask are valid
- bundle_ready  in  1  decode accepts the bundle
- bundle_data  out  SLOTS*WORD_W  word at pc+k goes to bits [WORD_W*(SLOTS-k)-1 -: WORD_W]; first word is in the MSB slot
- bundle_pc  out  ADDR_W  address of the bundle's first word
- slot_mask  out  SLOTS  bit SLOTS-1-k set when word k is nonzero; zero words are NOPs
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when the end-of-program bundle is detected

## Operation
- States: IDLE, FETCH, HOLD.
- Reset: state IDLE, pc 0, issue and capture counters 0. Every output is 0.
- IDLE:
  - start=1: pc<=start_pc, go to FETCH.
  - redirect_valid=1: treated as start, using redirect_pc.
- FETCH:
  - Issues SLOTS consecutive reads at pc+0 … pc+SLOTS-1, one per cycle, imem_rd_en=1.
  - Returning data is captured into the slot register in order.
  - After the last capture:
    - If all words are zero: done pulses, go to IDLE, bundle_valid stays 0.
    - Otherwise: go to HOLD with bundle_valid=1.
- HOLD:
  - Outputs hold steady while bundle_valid=1 and bundle_ready=0.
  - On handshake: pc<=pc+SLOTS, go to FETCH.
- Redirect in FETCH or HOLD:
  - Any fetch in flight is abandoned and bundle_valid drops next cycle.
  - Read data arriving in the following cycle is discarded.
  - pc<=redirect_pc, FETCH restarts next cycle.
- Redirect in the same cycle as a HOLD handshake: the bundle counts as consumed, and redirect_pc wins over pc+SLOTS.
- start is ignored outside IDLE.
- Address arithmetic is modulo 2^ADDR_W: pc+k and pc+SLOTS wrap silently.
- slot_mask and the zero test are computed from the complete assembled bundle.

## Timing
- FETCH entered at cycle T:
  - imem_rd_en high T..T+SLOTS-1.
  - Captures at T+1..T+SLOTS.
  - bundle_valid high from T+SLOTS+1.
- Throughput is one bundle per SLOTS+2 cycles when decode is always ready: handshake cycle plus fetch plus capture.
- done pulses at T+SLOTS+1; busy falls in the same cycle.
- Redirect at cycle R: first read at redirect_pc issues at R+1.
- bundle_valid is registered and never depends combinationally on bundle_ready.
- rst_n asserted mid-fetch clears all state and outputs immediately (asynchronous). No read strobe is issued until start.

## Structure
- Shared package vliw_pkg holds:
  - SLOTS, WORD_W, BUNDLE_W = SLOTS*WORD_W
  - the fetch-state enum
  - the slot-index helper that maps word k to its bit range, shared with the loader and decode
- One natural sub-module, vliw_bundle_assembler: slot register, capture counter, slot_mask, and the all-zero flag.
- FSM and pc stay in the top module.

## Test plan
- Memory preloaded with bundles at 0 and 8, zeros at 16; start_pc=0; ready=1 → bundle_pc 0 at cycle 9, bundle_pc 8 at cycle 19, done at cycle 29, busy=0 afterwards.
- Word 0 = 0x0208C000, word 6 = 0x9800DC56, others 0 → bundle_data[255:224]=0x0208C000, bundle_data[63:32]=0x9800DC56, slot_mask=8'b1000_0010.
- Hold bundle_ready=0 for 5 cycles in HOLD → data, pc and mask stable, no imem_rd_en; fetch of pc+8 starts the cycle after ready rises.
- redirect_valid with redirect_pc=26 on the 4th FETCH cycle → no stale word in the output; next bundle_pc=26, built from words 26..33.
- start_pc=1020, ADDR_W=10 → addresses 1020..1023 then 0..3; next bundle_pc=4.
- rst_n low mid-FETCH at word 5 → all outputs 0 immediately; after release a start at 8 yields a clean bundle at 8.
